// File: rtl/plot_point_feeder.sv
// rtl/plot_point_feeder.sv - Clamped (x,y) sample FIFO released one point per N frame events
// Samples are clamped to the plot window on entry and popped only on frame boundaries.
module plot_point_feeder #(
   parameter int DEPTH            = 16,
   parameter int X_LIMIT          = 511,
   parameter int Y_LIMIT          = 217,
   parameter int FRAMES_PER_POINT = 1
) (
   input  logic                     CLOCK_50,
   input  logic                     RESET_N,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [9:0]               in_x,
   input  logic [9:0]               in_y,
   input  logic                     frame_start,
   input  logic                     flush,
   output logic [17:0]              point,
   output logic                     point_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, SHOW} state_t;

   logic [17:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_fs_q;
   logic [7:0]    r_fc;
   logic [17:0]   r_point;
   logic          r_underrun;
   state_t        r_state;
   state_t        w_state_next;

   logic [8:0]    w_x_c;
   logic [8:0]    w_y_c;
   logic          w_fev;
   logic          w_rel;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   assign w_x_c   = (in_x > 10'(X_LIMIT)) ? 9'(X_LIMIT) : in_x[8:0];
   assign w_y_c   = (in_y > 10'(Y_LIMIT)) ? 9'(Y_LIMIT) : in_y[8:0];
   assign w_fev   = frame_start & ~r_fs_q;
   assign w_rel   = w_fev & (r_fc == 8'(FRAMES_PER_POINT - 1));
   assign w_empty = (r_count == '0);

   // Ready comes from the registered count only; a full FIFO never accepts, even when popping.
   assign in_ready = (r_count != CW'(DEPTH));
   assign w_push   = in_valid & in_ready & ~flush;
   assign w_pop    = w_rel & ~w_empty & ~flush;

   assign point       = r_point;
   assign point_valid = (r_state == SHOW);
   assign count       = r_count;
   assign underrun    = r_underrun;

   always_ff @(posedge CLOCK_50) begin
      if (w_push) r_mem[r_wptr] <= {w_x_c, w_y_c};
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_fs_q     <= 1'b0;
         r_fc       <= '0;
         r_point    <= '0;
         r_underrun <= 1'b0;
         r_state    <= IDLE;
      end else begin
         r_fs_q     <= frame_start;
         r_state    <= w_state_next;
         r_underrun <= w_rel & w_empty & ~flush;
         if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fc    <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
               r_rptr  <= r_rptr + 1'b1;
               r_point <= r_mem[r_rptr];
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_rel)      r_fc <= '0;
            else if (w_fev) r_fc <= r_fc + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (flush)                            w_state_next = IDLE;
      else if (r_state == IDLE && w_pop)    w_state_next = SHOW;
   end

endmodule

// File: tb/tb_plot_point_feeder.sv
// tb/tb_plot_point_feeder.sv - Queue-model self-checking bench for plot_point_feeder
module tb_plot_point_feeder;

   localparam int DEPTH = 16;
   typedef logic [17:0] pt_t;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N;
   logic       in_valid, frame_start, flush;
   logic [9:0] in_x, in_y;

   logic       ready_a, pv_a, und_a, ready_b, pv_b, und_b;
   logic [17:0] point_a, point_b;
   logic [4:0]  count_a, count_b;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   pt_t m_q0[$];
   pt_t m_q1[$];
   int  m_fc  [2];
   bit  m_fsq [2];
   pt_t m_pt  [2];
   bit  m_pv  [2];
   bit  m_und [2];

   always #10 CLOCK_50 = ~CLOCK_50;

   plot_point_feeder #(.DEPTH(DEPTH), .FRAMES_PER_POINT(1)) u_a (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(ready_a),
      .in_x(in_x), .in_y(in_y), .frame_start(frame_start), .flush(flush),
      .point(point_a), .point_valid(pv_a), .count(count_a), .underrun(und_a));

   plot_point_feeder #(.DEPTH(DEPTH), .FRAMES_PER_POINT(3)) u_b (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(ready_b),
      .in_x(in_x), .in_y(in_y), .frame_start(frame_start), .flush(flush),
      .point(point_b), .point_valid(pv_b), .count(count_b), .underrun(und_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Spec-level model: a plain queue of clamped points plus a frame-event counter.
   task automatic model_step(input int k, input int fpp, ref pt_t q[$]);
      bit fev, rel, push;
      int cx, cy;
      if (!RESET_N) begin
         q.delete();
         m_fc[k] = 0; m_fsq[k] = 0; m_pt[k] = '0; m_pv[k] = 0; m_und[k] = 0;
         return;
      end
      fev  = frame_start && !m_fsq[k];
      rel  = fev && (m_fc[k] == fpp - 1);
      push = in_valid && (q.size() < DEPTH);
      m_fsq[k] = frame_start;
      if (flush) begin
         q.delete();
         m_pv[k] = 0; m_fc[k] = 0; m_und[k] = 0;
         return;
      end
      m_und[k] = rel && (q.size() == 0);
      if (rel && q.size() != 0) begin
         m_pt[k] = q.pop_front();
         m_pv[k] = 1;
      end
      if (rel) m_fc[k] = 0;
      else if (fev) m_fc[k] = m_fc[k] + 1;
      if (push) begin
         cx = (int'(in_x) > 511) ? 511 : int'(in_x);
         cy = (int'(in_y) > 217) ? 217 : int'(in_y);
         q.push_back({cx[8:0], cy[8:0]});
      end
   endtask

   always @(posedge CLOCK_50) begin
      model_step(0, 1, m_q0);
      model_step(1, 3, m_q1);
   end

   always @(negedge CLOCK_50) begin
      if (chk_en) begin
         chk("a_point", point_a, m_pt[0]);
         chk("a_point_valid", pv_a, m_pv[0]);
         chk("a_count", count_a, m_q0.size());
         chk("a_in_ready", ready_a, m_q0.size() != DEPTH);
         chk("a_underrun", und_a, m_und[0]);
         chk("b_point", point_b, m_pt[1]);
         chk("b_point_valid", pv_b, m_pv[1]);
         chk("b_count", count_b, m_q1.size());
         chk("b_in_ready", ready_b, m_q1.size() != DEPTH);
         chk("b_underrun", und_b, m_und[1]);
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic push(input int x, input int y);
      in_valid = 1; in_x = 10'(x); in_y = 10'(y);
      tick();
      in_valid = 0;
   endtask

   task automatic frame(input int hold);
      frame_start = 1;
      repeat (hold) tick();
      frame_start = 0;
      tick();
   endtask

   task automatic do_flush();
      flush = 1;
      tick();
      flush = 0;
   endtask

   initial begin
      RESET_N = 0; in_valid = 0; in_x = 0; in_y = 0; frame_start = 0; flush = 0;
      repeat (2) tick();
      RESET_N = 1;
      chk_en = 1;
      // reset state
      chk("t1_point", point_a, 18'd0);
      chk("t1_point_valid", pv_a, 1'b0);
      chk("t1_count", count_a, 5'd0);
      chk("t1_in_ready", ready_a, 1'b1);
      chk("t1_underrun", und_a, 1'b0);

      // basic ordering
      push(10, 20);
      push(30, 40);
      frame(1);
      chk("t2_point1", point_a, {9'd10, 9'd20});
      chk("t2_valid1", pv_a, 1'b1);
      chk("t2_count1", count_a, 5'd1);
      frame(1);
      chk("t2_point2", point_a, {9'd30, 9'd40});
      chk("t2_count2", count_a, 5'd0);

      // clamp
      do_flush();
      push(700, 300);
      frame(1);
      chk("t3_clamp", point_a, {9'd511, 9'd217});
      push(511, 217);
      frame(1);
      chk("t3_limit", point_a, {9'd511, 9'd217});

      // full and simultaneous push/pop
      do_flush();
      for (int i = 0; i < DEPTH; i++) push(i, i + 1);
      chk("t4_full_count", count_a, 5'd16);
      chk("t4_full_ready", ready_a, 1'b0);
      push(5, 5);
      chk("t4_17th_dropped", count_a, 5'd16);
      frame(1);
      chk("t4_pop_head", point_a, {9'd0, 9'd1});
      chk("t4_count15", count_a, 5'd15);
      in_valid = 1; in_x = 10'd7; in_y = 10'd8; frame_start = 1;
      tick();
      in_valid = 0; frame_start = 0;
      tick();
      chk("t4_pushpop_count", count_a, 5'd15);

      // pacing with long frame_start levels
      do_flush();
      for (int i = 1; i <= 5; i++) push(i * 3, i * 5);
      for (int f = 0; f < 6; f++) begin
         frame(4);
         tick();
      end
      chk("t5_b_count", count_b, 5'd3);
      chk("t5_b_point", point_b, {9'd6, 9'd10});
      chk("t5_a_count", count_a, 5'd0);

      // underrun, flush and reset while queued
      do_flush();
      frame_start = 1;
      tick();
      chk("t6_underrun_hi", und_a, 1'b1);
      chk("t6_point_held", point_a, {9'd15, 9'd25});
      frame_start = 0;
      tick();
      chk("t6_underrun_lo", und_a, 1'b0);
      for (int i = 0; i < 5; i++) push(i, i);
      chk("t6_queued", count_a, 5'd5);
      do_flush();
      chk("t6_flush_count", count_a, 5'd0);
      chk("t6_flush_valid", pv_a, 1'b0);
      for (int i = 0; i < 5; i++) push(i, i);
      frame(1);
      RESET_N = 0; chk_en = 0;
      tick();
      RESET_N = 1; chk_en = 1;
      chk("t6_reset_count", count_a, 5'd0);
      chk("t6_reset_valid", pv_a, 1'b0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_x = 10'($urandom);
         in_y = 10'($urandom);
         if ($urandom_range(0, 3) == 0) frame_start = ~frame_start;
         flush = ($urandom_range(0, 199) == 0);
         tick();
      end
      in_valid = 0; flush = 0; frame_start = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
